cp0_unit: RTL

Coprocessor-0 for the P7 pipeline: owns SR, Cause, EPC and PRId, and evaluates exceptions and interrupts against the instruction held in the M stage. It is the source of the `req` flush that the M-stage and earlier pipeline registers consume. On the cycle `req` is high, every stage register loads a bubble, the M-stage register loads PC 0x0000_4180, and CP0 captures EPC, Cause and EXL for the faulting instruction.

---
 rtl/cp0_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC and PRId, plus exception/interrupt evaluation
// for the instruction held in M. req is the pipeline-wide flush request.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0114_5140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        slot_in,
  input  logic [4:0]  exc_in,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_en,
  input  logic        eret_en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Only the architecturally visible bits are stored; the rest read as 0.
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] fault_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        wr_sr;
  logic        wr_epc;

  assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (exc_in != 5'd0) & ~sr_exl;
  assign req     = ~rst & (int_req | exc_req);

  // A delay-slot fault restarts at the branch, one word earlier.
  assign fault_pc = (slot_in ? pc_in - 32'd4 : pc_in) & 32'hFFFF_FFFC;

  assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

  assign wr_sr  = mtc0_en & (cp0_addr == ADDR_SR);
  assign wr_epc = mtc0_en & (cp0_addr == ADDR_EPC);

  // Bypass lets an ERET directly behind an MTC0 EPC see the new target.
  assign epc_out = (wr_epc & ~req) ? wdata : epc;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    rdata = sr_word;
      ADDR_CAUSE: rdata = cause_word;
      ADDR_EPC:   rdata = epc;
      ADDR_PRID:  rdata = PRID;
      default:    rdata = 32'd0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        // Flush cycle: MTC0 and ERET in M are discarded along with the instruction.
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : exc_in;
        cause_bd  <= slot_in;
        epc       <= fault_pc;
      end else begin
        if (wr_sr) begin
          sr_im <= wdata[15:10];
          sr_ie <= wdata[0];
        end
        if (wr_epc) begin
          epc <= wdata;
        end
        // ERET wins over an MTC0 SR write of the EXL bit.
        if (eret_en) begin
          sr_exl <= 1'b0;
        end else if (wr_sr) begin
          sr_exl <= wdata[1];
        end
      end
    end
  end

endmodule
